mem_port_arbiter: RTL

Shares the single unified instruction/data memory port between the fetch stage and the memory stage of the pipelined RISC-V core. It grants one transaction at a time, holds the request to memory until acknowledged, and returns the result to the owning stage with a one-cycle valid pulse. It also drives stall lines for both stages, which sit alongside the hazard-detection stall in the pipeline control path. Data accesses win by default. A starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and memory stages, one transaction at a time.
// Data accesses win by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [AWIDTH-1:0]   if_addr,
  input  logic                flush_if,
  output logic [AWIDTH-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [AWIDTH-1:0]   dm_addr,
  input  logic [AWIDTH-1:0]   dm_wdata,
  input  logic [AWIDTH/8-1:0] dm_wstrb,
  output logic [AWIDTH-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [AWIDTH-1:0]   mem_wdata,
  output logic [AWIDTH/8-1:0] mem_wstrb,
  input  logic [AWIDTH-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int SW = AWIDTH / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic              owner_i_reg, owner_i_next;
  logic              flush_seen_reg, flush_seen_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [AWIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [AWIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic [SW-1:0]     mem_wstrb_reg, mem_wstrb_next;
  logic              if_valid_reg, if_valid_next;
  logic              dm_valid_reg, dm_valid_next;
  logic              fetch_live;

  // A fetch flushed in the same cycle is no longer a candidate for arbitration.
  assign fetch_live = if_req & ~flush_if;

  always_comb begin
    state_next      = state_reg;
    owner_i_next    = owner_i_reg;
    flush_seen_next = flush_seen_reg;
    cnt_next        = cnt_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_wstrb_next  = mem_wstrb_reg;
    if_valid_next   = 1'b0;
    dm_valid_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dm_req || fetch_live) begin
          if (dm_req && (!fetch_live || cnt_reg < CNT_LIMIT)) begin
            owner_i_next   = 1'b0;
            mem_we_next    = dm_we;
            mem_addr_next  = dm_addr;
            mem_wdata_next = dm_wdata;
            mem_wstrb_next = dm_wstrb;
            if (!fetch_live) begin
              cnt_next = '0;
            end else if (cnt_reg < CNT_LIMIT) begin
              cnt_next = cnt_reg + 1'b1;
            end
          end else begin
            owner_i_next   = 1'b1;
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr;
            mem_wdata_next = '0;
            mem_wstrb_next = '0;
            cnt_next       = '0;
          end
          mem_req_next = 1'b1;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        if (flush_if && owner_i_reg) flush_seen_next = 1'b1;
        if (mem_ack) begin
          mem_req_next  = 1'b0;
          if_valid_next = owner_i_reg & ~flush_seen_reg & ~flush_if;
          dm_valid_next = ~owner_i_reg;
          state_next    = DONE;
        end
      end
      DONE: begin
        // Requesters update at the end of this cycle, so no arbitration here.
        flush_seen_next = 1'b0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_i_reg    <= 1'b0;
      flush_seen_reg <= 1'b0;
      cnt_reg        <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_wstrb_reg  <= '0;
      if_valid_reg   <= 1'b0;
      dm_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_i_reg    <= owner_i_next;
      flush_seen_reg <= flush_seen_next;
      cnt_reg        <= cnt_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_wstrb_reg  <= mem_wstrb_next;
      if_valid_reg   <= if_valid_next;
      dm_valid_reg   <= dm_valid_next;
    end
  end

  logic              capture;
  logic [AWIDTH-1:0] rdata [2];

  assign capture = (state_reg == BUSY) && mem_ack;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdata
      logic              take;
      logic [AWIDTH-1:0] rdata_reg;
      // Slot 1 holds fetch data; slot 0 captures loads only so stores leave it untouched.
      if (gi == 1) begin : g_fetch
        assign take = capture & owner_i_reg;
      end else begin : g_data
        assign take = capture & ~owner_i_reg & ~mem_we_reg;
      end
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_reg <= '0;
        end else if (take) begin
          rdata_reg <= mem_rdata;
        end
      end
      assign rdata[gi] = rdata_reg;
    end
  endgenerate

  assign if_rdata  = rdata[1];
  assign dm_rdata  = rdata[0];
  assign if_valid  = if_valid_reg;
  assign dm_valid  = dm_valid_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign stall_if  = if_req & ~if_valid_reg;
  assign stall_mem = dm_req & ~dm_valid_reg;

endmodule
